// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter (8N1) fed by a small power-of-two FIFO.
// The divider is latched per frame, and frames run back-to-back while bytes are queued.
module uart_tx_fifo #(
  parameter int DEPTH   = 4,
  parameter int DIV_MIN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] div_cfg,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        ser_tx,
  output logic        busy,
  output logic [4:0]  level,
  output logic        overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic [1:0]    state;
  logic [15:0]   div_lat, div_cnt, div_eff;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          push, pop, bit_end;

  assign wr_ready = (count < 5'(DEPTH));
  assign level    = count;
  assign busy     = (state != IDLE) || (count != 5'd0);
  assign div_eff  = (div_cfg < 16'(DIV_MIN)) ? 16'(DIV_MIN) : div_cfg;
  assign bit_end  = (div_cnt == div_lat - 16'd1);
  assign push     = wr_en && wr_ready;
  // A new frame starts from IDLE or straight out of the final STOP cycle.
  assign pop      = (count != 5'd0) &&
                    ((state == IDLE) || (state == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (wr_en && !wr_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_lat <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ser_tx  <= 1'b1;
    end else begin
      // Line is driven from the registered state, so it trails the FSM by one cycle.
      case (state)
        START:   ser_tx <= 1'b0;
        DATA:    ser_tx <= shreg[0];
        default: ser_tx <= 1'b1;
      endcase

      if (pop) begin
        shreg   <= mem[rd_ptr];
        div_lat <= div_eff;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            div_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_cnt == 3'd7) state <= STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= pop ? START : IDLE;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: writes push {byte, divider}; a mid-bit line monitor pops and compares frames.
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div_cfg;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_ready, ser_tx, busy, overflow;
  logic [4:0]  level;

  typedef struct {
    logic [7:0] data;
    int         div;
  } sb_t;

  sb_t sb[$];
  int  starts[$];
  int  n_chk = 0, n_err = 0, cyc = 0;
  bit  mon_on = 1'b1;
  bit  m_act = 1'b0;
  logic m_prev = 1'b1;
  int  m_cnt, m_div, m_k;
  logic [7:0] m_byte;
  sb_t m_e;

  uart_tx_fifo #(.DEPTH(4), .DIV_MIN(4)) dut (
    .clk(clk), .reset(reset), .div_cfg(div_cfg), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .ser_tx(ser_tx), .busy(busy), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Receiver: samples each bit at mid-period, counting from the falling start edge.
  always @(negedge clk) begin
    if (reset || !mon_on) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (m_prev === 1'b1 && ser_tx === 1'b0) begin
        if (sb.size() == 0) chk("frame_expected", sb.size(), 1);
        else begin
          m_act = 1'b1;
          m_cnt = 0;
          m_div = sb[0].div;
          m_byte = '0;
          starts.push_back(cyc);
        end
      end
    end else begin
      m_cnt++;
      if (m_cnt >= m_div / 2 && (m_cnt - m_div / 2) % m_div == 0) begin
        m_k = (m_cnt - m_div / 2) / m_div;
        if (m_k == 0) chk("start_bit", ser_tx, 0);
        else if (m_k <= 8) m_byte[m_k-1] = ser_tx;
        else begin
          chk("stop_bit", ser_tx, 1);
          m_e = sb.pop_front();
          chk("rx_byte", m_byte, m_e.data);
          m_act = 1'b0;
        end
      end
    end
    m_prev = ser_tx;
  end

  task automatic wr(input logic [7:0] d, input bit acc, input int div);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    if (acc) sb.push_back('{d, div});
  endtask

  task automatic wr_stop();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while ((sb.size() != 0 || m_act || busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", (n < lim), 1);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; div_cfg = 16'd106;
    #3;
    chk("rst_ser_tx", ser_tx, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single frame latency and 0x55 pattern
    starts.delete();
    wr(8'h55, 1, 106);
    wr_stop();
    chk("lat_level", level, 1);
    chk("lat_tx_e0", ser_tx, 1);
    @(negedge clk);
    chk("lat_tx_e1", ser_tx, 1);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_tx_e2", ser_tx, 0);
    wait_done(1300);
    chk("idle_tx", ser_tx, 1);
    chk("idle_busy", busy, 0);
    chk("n_frames_1", starts.size(), 1);

    // Three back-to-back frames
    starts.delete();
    wr(8'h41, 1, 106); wr(8'h42, 1, 106); wr(8'h43, 1, 106);
    wr_stop();
    wait_done(3500);
    chk("n_frames_3", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_gap_1", starts[1] - starts[0], 1060);
      chk("b2b_gap_2", starts[2] - starts[1], 1060);
    end

    // Overflow while a frame is in flight
    div_cfg = 16'd20;
    starts.delete();
    wr(8'h10, 1, 20);
    wr_stop();
    @(negedge clk);
    chk("ovf_pre_level", level, 0);
    chk("ovf_pre_flag", overflow, 0);
    wr(8'hA1, 1, 20); wr(8'hB2, 1, 20); wr(8'hC3, 1, 20); wr(8'hD4, 1, 20);
    wr(8'hE5, 0, 20);
    wr_stop();
    chk("ovf_level", level, 4);
    chk("ovf_wr_ready", wr_ready, 0);
    chk("ovf_flag", overflow, 1);
    wait_done(1500);
    chk("ovf_frames", starts.size(), 5);
    chk("ovf_sticky", overflow, 1);

    // Divider clamp
    div_cfg = 16'd2;
    starts.delete();
    wr(8'hA5, 1, 4); wr(8'h5A, 1, 4);
    wr_stop();
    wait_done(200);
    chk("clamp_frames", starts.size(), 2);
    if (starts.size() == 2) chk("clamp_len", starts[1] - starts[0], 40);

    // Divider change mid-frame only affects the next frame
    div_cfg = 16'd106;
    starts.delete();
    wr(8'h3C, 1, 106); wr(8'hC3, 1, 50);
    wr_stop();
    repeat (300) @(negedge clk);
    div_cfg = 16'd50;
    begin
      int n = 0;
      while (starts.size() < 2 && n < 2000) begin @(negedge clk); n++; end
      chk("mid_second_start", (n < 2000), 1);
    end
    wr(8'h99, 1, 50);
    wr_stop();
    wait_done(2000);
    chk("mid_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("mid_len_1", starts[1] - starts[0], 1060);
      chk("mid_len_2", starts[2] - starts[1], 500);
    end

    // Reset during DATA bit 3 with two bytes queued
    mon_on = 1'b0;
    div_cfg = 16'd20;
    wr(8'hF0, 0, 20); wr(8'h11, 0, 20); wr(8'h22, 0, 20);
    wr_stop();
    begin
      int n = 0;
      while (ser_tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      chk("rst_fall_seen", (n < 100), 1);
    end
    repeat (4 * 20 + 10) @(negedge clk);
    chk("rst_pre_tx", ser_tx, 0);
    chk("rst_pre_level", level, 2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx", ser_tx, 1);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    begin
      int lows = 0;
      repeat (400) begin
        @(negedge clk);
        if (ser_tx !== 1'b1) lows++;
      end
      chk("rst_no_frame", lows, 0);
    end
    chk("rst_post_busy", busy, 0);
    chk("rst_post_ready", wr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the transmit FIFO capacity in bytes (power of two, 2..16).
REQ-002 Parameter DIV_MIN, default 4, SHALL set the lower clamp for the bit-period divider.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 div_cfg  input  16  SHALL give the bit period in clk cycles (106 gives the SoC default baud).
REQ-006 wr_en  input  1  SHALL be the byte-write strobe.
REQ-007 wr_data  input  8  SHALL be the byte to enqueue.
REQ-008 wr_ready  output  1  SHALL be high when the FIFO is not full (registered count < DEPTH).
REQ-009 ser_tx  output  1  SHALL be the serial line, idle high.
REQ-010 busy  output  1  SHALL be high while the FSM is outside IDLE or the FIFO is non-empty.
REQ-011 level  output  5  SHALL be the current FIFO occupancy.
REQ-012 overflow  output  1  SHALL be a sticky flag set by any write dropped while full.

Function
REQ-013 A write SHALL be accepted on a rising edge with wr_en=1 and wr_ready=1; level increments on that edge.
REQ-014 A write with wr_ready=0 SHALL be dropped, leave FIFO contents unchanged and set overflow on that edge.
REQ-015 wr_ready SHALL derive from the registered count only; a pop in the same cycle SHALL NOT admit a write to a full FIFO.
REQ-016 Simultaneous accepted write and pop SHALL leave level unchanged and preserve byte order.
REQ-017 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 IDLE->START SHALL occur on the first edge where level>0; that edge pops the head byte into the shift register and latches the divider.
REQ-020 The latched divider SHALL equal max(div_cfg, DIV_MIN); div_cfg changes mid-frame SHALL NOT affect the current frame.
REQ-021 ser_tx SHALL be registered: 0 in START, shift-register LSB in DATA, 1 in STOP and IDLE.
REQ-022 Each of START, each of 8 DATA bits (LSB first) and STOP SHALL last exactly the latched divider cycles; a frame SHALL be 10*div cycles.
REQ-023 A bit counter SHALL count 0..7 in DATA; leaving DATA after bit 7 SHALL enter STOP.
REQ-024 At the end of STOP, if level>0 the FSM SHALL go directly to START (popping the next byte) with no idle gap; otherwise it returns to IDLE.
REQ-025 ser_tx SHALL fall on the second rising edge after the edge accepting a byte into an empty, idle block.

Reset
REQ-026 While reset=1: ser_tx=1, wr_ready=1, busy=0, level=0, overflow=0, FSM=IDLE, pointers and counters zero, independent of clk.
REQ-027 Reset asserted mid-frame SHALL drive ser_tx high immediately, discard the in-flight byte and all queued bytes.
REQ-028 overflow SHALL be cleared only by reset.

Verification
REQ-029 div_cfg=106, write 0x55 at idle -> ser_tx low 2 edges later, line pattern 0,1,0,1,0,1,0,1,0,1 each 106 cycles, idle high after 1060 cycles, busy low.
REQ-030 div_cfg=106, write 0x41,0x42,0x43 on consecutive cycles -> three contiguous frames totalling 3180 cycles, no high gap between stop and next start, bytes in order.
REQ-031 During a frame with an empty FIFO, write 5 bytes on consecutive cycles -> first 4 accepted, level=4, wr_ready=0, fifth dropped, overflow=1; all 4 bytes transmitted afterwards.
REQ-032 div_cfg=2 -> divider clamped to 4, frame length 40 cycles; div_cfg changed 106->50 mid-frame -> current frame stays 1060 cycles, next frame 500.
REQ-033 Assert reset during DATA bit 3 with 2 bytes queued -> ser_tx=1 and level=0 before the next clk edge; after release, no frame is transmitted.
REQ-034 Bench SHALL sample ser_tx at mid-bit (div/2 after the falling edge, then every div) and check the stop bit is 1.
